// File: rtl/iic_master_wr.sv
// iic_master_wr: single-shot IIC write master (START, {dev_addr,W}, reg_addr, wr_data, STOP).
// Optional macro IIC_RETRY_EN: after a NACK the whole write is re-issued, up to RETRY_MAX times.
module iic_master_wr #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int SCL_FREQ  = 100_000,
   parameter int RETRY_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   input  logic       SDA_in,
   output logic       SCL,
   output logic       SDA_out,
   output logic       SDA_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err
);
   localparam int PH_CNT = CLK_FREQ / (4 * SCL_FREQ);
   localparam int PW     = (PH_CNT > 1) ? $clog2(PH_CNT) : 1;
   localparam int RW     = $clog2(RETRY_MAX + 2);
`ifdef IIC_RETRY_EN
   localparam int RETRY_LIM = RETRY_MAX;
`else
   localparam int RETRY_LIM = 0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          nack_q, nack_d;
   logic          scl_q, scl_d, oe_q, oe_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [7:0]    adr_q, adr_d, reg_q, reg_d, dat_q, dat_d;
   logic [7:0]    tx_byte;
   logic          ph_end, bit_end;

   assign ph_end  = (ph_q == PW'(PH_CNT - 1));
   assign bit_end = ph_end && (qtr_q == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         retry_q <= '0;
         nack_q  <= 1'b0;
         scl_q   <= 1'b1;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         retry_q <= retry_d;
         nack_q  <= nack_d;
         scl_q   <= scl_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      adr_q <= adr_d;
      reg_q <= reg_d;
      dat_q <= dat_d;
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      retry_d = retry_q;
      nack_d  = nack_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      adr_d   = adr_q;
      reg_d   = reg_q;
      dat_d   = dat_q;
      if (state_q != S_IDLE) begin
         ph_d = ph_end ? '0 : ph_q + 1'b1;
         if (ph_end) qtr_d = qtr_q + 2'd1;
      end
      unique case (state_q)
         // done_q blocks a request landing in the completion cycle
         S_IDLE: if (start && !done_q) begin
            adr_d   = {dev_addr, 1'b0};
            reg_d   = reg_addr;
            dat_d   = wr_data;
            err_d   = 1'b0;
            retry_d = '0;
            busy_d  = 1'b1;
            ph_d    = '0;
            qtr_d   = '0;
            state_d = S_START;
         end
         S_START: if (bit_end) begin
            bit_d   = 3'd7;
            state_d = S_ADDR;
         end
         S_ADDR, S_REG, S_DATA: if (bit_end) begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
               case (state_q)
                  S_ADDR:  state_d = S_ACK1;
                  S_REG:   state_d = S_ACK2;
                  default: state_d = S_ACK3;
               endcase
            end
         end
         S_ACK1, S_ACK2, S_ACK3: begin
            if ((qtr_q == 2'd2) && ph_end) nack_d = SDA_in;
            if (bit_end) begin
               if (nack_q) begin
                  err_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  case (state_q)
                     S_ACK1:  state_d = S_REG;
                     S_ACK2:  state_d = S_DATA;
                     default: state_d = S_STOP;
                  endcase
               end
            end
         end
         S_STOP: if (bit_end) begin
            if (err_q && (retry_q != RW'(RETRY_LIM))) begin
               retry_d = retry_q + 1'b1;
               err_d   = 1'b0;
               state_d = S_START;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_d)
         S_ADDR:  tx_byte = adr_q;
         S_REG:   tx_byte = reg_q;
         default: tx_byte = dat_q;
      endcase
   end

   // Bus pins are decoded from the next state so they come straight off flops.
   always_comb begin
      scl_d = 1'b1;
      oe_d  = 1'b0;
      case (state_d)
         S_START: begin
            scl_d = (qtr_d != 2'd3);
            oe_d  = (qtr_d != 2'd0);
         end
         S_ADDR, S_REG, S_DATA: begin
            scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
            oe_d  = ~tx_byte[bit_d];
         end
         S_ACK1, S_ACK2, S_ACK3: scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
         S_STOP: begin
            scl_d = (qtr_d != 2'd0);
            oe_d  = (qtr_d <= 2'd1);
         end
         default: ;
      endcase
   end

   assign SCL     = scl_q;
   assign SDA_oe  = oe_q;
   assign SDA_out = ~oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = err_q;
endmodule
